// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the digital-clock counter chain.
// Holds the operating-mode encoding and the terminal values that the
// seconds/minutes/hours counters wrap on.
package clock_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  // Mode key walks the ring RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      RUN:      return SET_HOUR;
      SET_HOUR: return SET_MIN;
      SET_MIN:  return SET_SEC;
      default:  return RUN;
    endcase
  endfunction

endpackage

// File: rtl/key_edge.sv
// key_edge: turns an asynchronous active-high board key into a one-cycle
// registered event on its rising edge. A 2-flop synchronizer brings the key
// into the clk domain; with CLOCK_KEY_DEBOUNCE_EN defined, a debounce stage
// only passes a new level once it has been stable for DEB_CYCLES cycles.
module key_edge
  import clock_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic evt
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_q;

  // Two-flop synchronizer for the asynchronous key input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

`ifdef CLOCK_KEY_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] deb_cnt;
  logic          deb;

  // Debounce: count consecutive cycles the synchronized key differs from
  // the accepted level; adopt the new level on the DEB_CYCLES-th such cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt <= '0;
      deb     <= 1'b0;
    end else if (sync2 == deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt <= '0;
      deb     <= sync2;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign level = deb;
`else
  localparam int unused_deb_cycles = DEB_CYCLES;

  assign level = sync2;
`endif

  // Rising-edge detect, registered so the event is a clean one-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= 1'b0;
      evt     <= 1'b0;
    end else begin
      level_q <= level;
      evt     <= level & ~level_q;
    end
  end

endmodule

// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl: mode and sequencing controller for the clock counters.
// Generates the seconds timebase, cascades step strobes in RUN, steps the
// selected field from the increment key in the set modes, and drives the
// blink enable for the field being set. Key debounce is built only when
// CLOCK_KEY_DEBOUNCE_EN is defined (see key_edge).
module clock_step_ctrl
  import clock_pkg::*;
#(
  parameter int DIV        = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] SW,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic        sec_max,
  input  logic        min_max,
  output logic        sec_step,
  output logic        min_step,
  output logic        hour_step,
  output logic [1:0]  mode,
  output logic        blink
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  localparam int HALF = DIV / 2;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

  mode_t         state_q;
  mode_t         state_d;
  logic          mode_evt;
  logic          inc_evt;
  logic          inc_ok;
  logic          pause;
  logic          tick;
  logic [PW-1:0] pre_q;
  logic [BW-1:0] bcnt_q;
  logic          sec_d;
  logic          min_d;
  logic          hour_d;
  logic          unused_sw;

  assign pause     = SW[0];
  assign unused_sw = ^SW[17:1];

  key_edge #(.DEB_CYCLES(DEB_CYCLES)) u_mode_key (
    .clk (clk),
    .rst (rst),
    .key (key_mode),
    .evt (mode_evt)
  );

  key_edge #(.DEB_CYCLES(DEB_CYCLES)) u_inc_key (
    .clk (clk),
    .rst (rst),
    .key (key_inc),
    .evt (inc_evt)
  );

  // A mode change wins over a simultaneous increment.
  assign inc_ok = inc_evt & ~mode_evt;

  // The timebase fires only while actually counting in RUN.
  assign tick = (state_q == RUN) && !pause && (pre_q == PRE_LAST);

  // Mode state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next mode and step decode: cascade on ticks in RUN, single field in set modes.
  always_comb begin
    state_d = state_q;
    sec_d   = 1'b0;
    min_d   = 1'b0;
    hour_d  = 1'b0;
    if (mode_evt) begin
      state_d = next_mode(state_q);
    end
    case (state_q)
      RUN: begin
        sec_d  = tick;
        min_d  = tick & sec_max;
        hour_d = tick & sec_max & min_max;
      end
      SET_HOUR: hour_d = inc_ok;
      SET_MIN:  min_d  = inc_ok;
      SET_SEC:  sec_d  = inc_ok;
    endcase
  end

  // Prescaler: runs in RUN, holds while paused, cleared in any set mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else if (state_q != RUN) begin
      pre_q <= '0;
    end else if (!pause) begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
    end
  end

  // Registered step strobes, each high for a single cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_step  <= 1'b0;
      min_step  <= 1'b0;
      hour_step <= 1'b0;
    end else begin
      sec_step  <= sec_d;
      min_step  <= min_d;
      hour_step <= hour_d;
    end
  end

  // Blink: solid in RUN, restarts high on every mode change, then toggles every DIV/2 cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q <= '0;
      blink  <= 1'b1;
    end else if (mode_evt || (state_q == RUN)) begin
      bcnt_q <= '0;
      blink  <= 1'b1;
    end else if (bcnt_q == BLINK_LAST) begin
      bcnt_q <= '0;
      blink  <= ~blink;
    end else begin
      bcnt_q <= bcnt_q + 1'b1;
    end
  end

  assign mode = state_q;

endmodule

// File: tb/tb_clock_step_ctrl.sv
// tb_clock_step_ctrl: directed, self-checking bench for clock_step_ctrl with
// DIV=4, DEB_CYCLES=3. Covers the free-running timebase, cascade, pause,
// mode ring, set-mode increments, key collision, async reset and, when
// CLOCK_KEY_DEBOUNCE_EN is defined, debounce filtering.
module tb_clock_step_ctrl;

  localparam int DIV = 4;
  localparam int DEB = 3;
`ifdef CLOCK_KEY_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif
  // Negedge (counted from the key change) at which the result is visible.
  localparam int VIS = LAT + 1;

  logic        clk;
  logic        rst;
  logic [17:0] SW;
  logic        key_mode;
  logic        key_inc;
  logic        sec_max;
  logic        min_max;
  logic        sec_step;
  logic        min_step;
  logic        hour_step;
  logic [1:0]  mode;
  logic        blink;
  logic [2:0]  steps;

  int n_checks;
  int n_fails;

  assign steps = {sec_step, min_step, hour_step};

  clock_step_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .SW        (SW),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .sec_max   (sec_max),
    .min_max   (min_max),
    .sec_step  (sec_step),
    .min_step  (min_step),
    .hour_step (hour_step),
    .mode      (mode),
    .blink     (blink)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case the run ever stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [17:0] sw_v, input logic smax, input logic mmax);
    SW      = sw_v;
    sec_max = smax;
    min_max = mmax;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  // Press and hold the mode key, checking the switch point, blink restart
  // and (when entering RUN) the first timebase step.
  task automatic pressMode(input logic [1:0] old_mode, input logic [1:0] new_mode);
    key_mode = 1'b1;
    for (int c = 1; c <= VIS; c++) begin
      nextCycle();
      if (c == VIS - 1) checkOutput("mode_before", mode, old_mode);
    end
    checkOutput("mode_after", mode, new_mode);
    checkOutput("blink_entry", blink, 1);
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
      if (new_mode == 2'd0) begin
        checkOutput("blink_run", blink, 1);
        checkOutput("run_first_step", steps, (i == 4) ? 3'b100 : 3'b000);
      end else begin
        checkOutput("blink_set", blink, (i == 2 || i == 3) ? 1'b0 : 1'b1);
        checkOutput("set_idle_steps", steps, 3'b000);
      end
    end
    checkOutput("mode_held", mode, new_mode);
    key_mode = 1'b0;
    repeat (8) nextCycle();
    checkOutput("mode_settled", mode, new_mode);
  endtask

  // Press and hold the increment key; exactly one strobe at VIS.
  task automatic pressInc(input logic [2:0] exp_steps);
    key_inc = 1'b1;
    for (int c = 1; c <= VIS + 4; c++) begin
      nextCycle();
      checkOutput("inc_step", steps, (c == VIS) ? exp_steps : 3'b000);
    end
    key_inc = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      nextCycle();
      checkOutput("inc_quiet", steps, 3'b000);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b0;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    applyStimulus(18'h0, 1'b0, 1'b0);

    // Reset values.
    repeat (3) nextCycle();
    checkOutput("rst_mode", mode, 0);
    checkOutput("rst_steps", steps, 0);
    checkOutput("rst_blink", blink, 1);
    rst = 1'b1;

    // Free-running timebase: a seconds step every 4 cycles, no cascade.
    for (int i = 1; i <= 12; i++) begin
      nextCycle();
      checkOutput("run_free", steps, (i % 4 == 0) ? 3'b100 : 3'b000);
    end
    checkOutput("run_mode", mode, 0);
    checkOutput("run_blink", blink, 1);

    // Cascade, with the unused switches set to show they are ignored.
    applyStimulus(18'h3FFFE, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
      checkOutput("cascade_all", steps, (i == 4) ? 3'b111 : 3'b000);
    end
    applyStimulus(18'h3FFFE, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
      checkOutput("cascade_min", steps, (i == 4) ? 3'b110 : 3'b000);
    end
    applyStimulus(18'h3FFFE, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
      checkOutput("cascade_none", steps, (i == 4) ? 3'b100 : 3'b000);
    end
    applyStimulus(18'h0, 1'b0, 1'b0);

    // Pause mid-count: prescaler holds at 2, resumes with 2 cycles left.
    for (int i = 1; i <= 2; i++) begin
      nextCycle();
      checkOutput("pre_pause", steps, 3'b000);
    end
    applyStimulus(18'h1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      nextCycle();
      checkOutput("pause_hold", steps, 3'b000);
    end
    applyStimulus(18'h0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("pause_resume1", steps, 3'b000);
    nextCycle();
    checkOutput("pause_resume2", steps, 3'b100);

    // Mode ring with an increment in each set mode.
    pressMode(2'd0, 2'd1);
    pressInc(3'b001);
    pressMode(2'd1, 2'd2);
    pressInc(3'b010);
    pressMode(2'd2, 2'd3);
    pressInc(3'b100);
    pressMode(2'd3, 2'd0);

    // Mode and increment together in SET_HOUR: mode wins, no step.
    pressMode(2'd0, 2'd1);
    key_mode = 1'b1;
    key_inc  = 1'b1;
    for (int c = 1; c <= VIS + 4; c++) begin
      nextCycle();
      checkOutput("both_steps", steps, 3'b000);
      if (c == VIS) checkOutput("both_mode", mode, 2'd2);
    end
    key_mode = 1'b0;
    key_inc  = 1'b0;
    repeat (8) nextCycle();
    checkOutput("both_settled", mode, 2'd2);

    // Async reset from SET_SEC while blink is low.
    pressMode(2'd2, 2'd3);
    repeat (2) nextCycle();
    checkOutput("blink_phase", blink, 0);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_mode", mode, 0);
    checkOutput("async_rst_blink", blink, 1);
    checkOutput("async_rst_steps", steps, 3'b000);
    repeat (2) nextCycle();
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
      checkOutput("post_rst_run", steps, (i == 4) ? 3'b100 : 3'b000);
    end

`ifdef CLOCK_KEY_DEBOUNCE_EN
    // Debounce: short glitch is filtered, a 6-cycle pulse gives one step.
    pressMode(2'd0, 2'd1);
    pressMode(2'd1, 2'd2);
    pressMode(2'd2, 2'd3);
    key_inc = 1'b1;
    repeat (2) nextCycle();
    key_inc = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      nextCycle();
      checkOutput("deb_glitch", steps, 3'b000);
    end
    key_inc = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      nextCycle();
      if (c == 6) key_inc = 1'b0;
      checkOutput("deb_pulse", steps, (c == VIS) ? 3'b100 : 3'b000);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/clock_step_ctrl.md
# clock_step_ctrl

Mode and sequencing controller for the digital-clock counter chain. Generates the 1 Hz timebase and the one-cycle step strobes that advance the seconds, minutes and hours counters. In RUN mode it cascades steps on terminal counts. In the set modes it steps only the selected field from the increment key. Sits between the board keys/switches and the three counter instances; owns no time value itself.

## Interface
- DIV, 50_000_000: clk cycles per seconds step; legal ≥ 4.
- DEB_CYCLES, 1_000_000: stable-sample count for key debounce (used only with debounce compiled in).
- clk  input  1  system clock; every register is on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- SW  input  18  board switches; only SW[0] (pause) is used, SW[17:1] ignored.
- key_mode  input  1  mode key, active-high, asynchronous to clk.
- key_inc  input  1  increment key, active-high, asynchronous to clk.
- sec_max  input  1  seconds counter currently at terminal value (59).
- min_max  input  1  minutes counter currently at terminal value (59).
- sec_step  output  1  one-cycle advance strobe to seconds counter.
- min_step  output  1  one-cycle advance strobe to minutes counter.
- hour_step  output  1  one-cycle advance strobe to hours counter.
- mode  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
- blink  output  1  display-enable for the selected field; constant 1 in RUN.

## Operation
- Reset values: mode=RUN, all steps 0, blink=1, prescaler 0, key pipelines 0.
- Key front end per key: 2-flop synchronizer, then rising-edge detect; produces a one-cycle internal event.
- FSM: a mode event advances RUN→SET_HOUR→SET_MIN→SET_SEC→RUN. No other transitions.
- Prescaler: counter width $clog2(DIV); counts 0..DIV-1 and wraps; tick = (count==DIV-1).
  - Counts only in RUN with SW[0]=0.
  - Holds its value while SW[0]=1 in RUN.
  - Forced to 0 in every set mode.
- RUN outputs on a tick:
  - sec_step=1.
  - min_step=sec_max.
  - hour_step=sec_max&min_max.
  - sec_max and min_max are sampled in the tick cycle.
- Set mode outputs: an inc event pulses only the selected field's step (SET_HOUR→hour_step, etc.). No cascade; sec_max and min_max are ignored.
- Inc events in RUN are discarded.
- A mode event and an inc event in the same cycle: mode change taken, inc dropped.
- blink in set modes:
  - Toggles every DIV/2 cycles, driven by its own half-period counter.
  - Starts at 1 on set-mode entry.
  - Restarts at 1 on every mode change.

## Timing
- All outputs are registered. Each step is high for exactly one cycle.
- RUN: a tick in cycle t gives steps high in cycle t+1. Steady-state period is DIV cycles.
- Entering RUN from SET_SEC clears the prescaler; the first sec_step comes DIV cycles after mode reads 0.
- Without debounce: key high first sampled at edge k → event at edge k+2 → mode update or step strobe visible after edge k+3.
- A key held high produces one event only; the next event requires a low sample first.
- Asserting rst mid-operation returns all state to reset values immediately. Any step in flight is lost, not completed.

## Configuration
- CLOCK_KEY_DEBOUNCE_EN defined: a debounce stage sits between synchronizer and edge detect.
  - Its output changes only after the synchronized input has been stable for DEB_CYCLES consecutive cycles.
  - Event latency = 3 + DEB_CYCLES cycles.
  - Glitches shorter than DEB_CYCLES produce no event.
- Not defined: no debounce logic is built, DEB_CYCLES is unused, and latency is as in Timing.

## Structure
- Package clock_pkg holds:
  - mode enum (RUN, SET_HOUR, SET_MIN, SET_SEC) and its 2-bit width.
  - terminal values SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, shared with the counters.
- Sub-module key_edge contains synchronizer, optional debounce and edge detect. It is instantiated twice (mode and inc keys).
- FSM, prescaler, blink counter and step logic live in the top module.

## Test plan
Run with DIV=4, DEB_CYCLES=3.
- Reset, SW=0, sec_max=min_max=0 → sec_step pulses every 4 cycles; min_step and hour_step stay 0; mode=0; blink=1.
- sec_max=1 and min_max=1 held across a tick → sec_step, min_step and hour_step all pulse in the same cycle.
- SW[0]=1 for 10 cycles mid-count → no steps. On release, the next sec_step arrives after the remaining prescale cycles, not after a full 4.
- Four mode presses → mode goes 1,2,3,0. In mode 2, one inc press → a single min_step and no sec_step. The first RUN sec_step comes 4 cycles after mode=0.
- Mode and inc edges in the same cycle while in mode 1 → mode=2 and no step. Assert rst while in mode 3 → mode=0 and blink=1 at once.
- With CLOCK_KEY_DEBOUNCE_EN, a 2-cycle key_inc pulse in mode 3 → no sec_step. A 6-cycle pulse → exactly one sec_step, 6 cycles after the rise.
